// File: rtl/compare_sequencer.sv
// Round-based controller for the load/shift/compare/tally datapath: per round it loads the
// counters, runs them for TICKS enabled steps, samples the comparator and pulses one tally enable.
`timescale 1ns/1ps
module compare_sequencer #(
  parameter int ROUNDS = 4,
  parameter int TICKS  = 3
) (
  input  logic       compare_sequencer_clk,
  input  logic       compare_sequencer_rst,
  input  logic       compare_sequencer_en,
  input  logic       compare_sequencer_start,
  input  logic       compare_sequencer_abort,
  input  logic [2:0] compare_sequencer_cmp,
  output logic       compare_sequencer_load,
  output logic [3:0] compare_sequencer_dir,
  output logic [1:0] compare_sequencer_shift,
  output logic       compare_sequencer_sr,
  output logic [2:0] compare_sequencer_tally,
  output logic [7:0] compare_sequencer_round,
  output logic       compare_sequencer_busy,
  output logic       compare_sequencer_done,
  output logic       compare_sequencer_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);
  localparam logic [7:0] LAST_STEP  = 8'(TICKS - 1);

  state_t     state_q, state_d;
  logic [7:0] round_q, round_d;
  logic [7:0] step_q, step_d;
  logic [2:0] tally_q, tally_d;
  logic       err_q, err_d;

  function automatic logic one_hot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  always_ff @(posedge compare_sequencer_clk or negedge compare_sequencer_rst) begin
    if (!compare_sequencer_rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      step_q  <= '0;
      tally_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      step_q  <= step_d;
      tally_q <= tally_d;
      err_q   <= err_d;
    end
  end

  // tally_d defaults to zero so a pulse never outlives one clock, even when en stalls the FSM.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    step_d  = step_q;
    tally_d = '0;
    err_d   = err_q;
    if (compare_sequencer_abort) begin
      state_d = S_IDLE;
      round_d = '0;
      step_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (compare_sequencer_start) begin
            state_d = S_LOAD;
            round_d = '0;
            step_d  = '0;
            err_d   = 1'b0;
          end
        end
        S_LOAD: begin
          if (compare_sequencer_en) begin
            state_d = S_RUN;
            step_d  = '0;
          end
        end
        S_RUN: begin
          if (compare_sequencer_en) begin
            step_d = step_q + 8'd1;
            if (step_q == LAST_STEP) state_d = S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (compare_sequencer_en) begin
            if (one_hot3(compare_sequencer_cmp)) tally_d = compare_sequencer_cmp;
            else err_d = 1'b1;
            if (round_q == LAST_ROUND) begin
              state_d = S_DONE;
            end else begin
              round_d = round_q + 8'd1;
              state_d = S_LOAD;
            end
          end
        end
        S_DONE: begin
          if (!compare_sequencer_start) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Round-derived controls are only driven while a round is in progress.
  always_comb begin
    compare_sequencer_busy  = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_SAMPLE);
    compare_sequencer_load  = (state_q == S_LOAD);
    compare_sequencer_done  = (state_q == S_DONE);
    compare_sequencer_shift = '0;
    compare_sequencer_sr    = 1'b0;
    compare_sequencer_dir   = '0;
    if (compare_sequencer_busy) begin
      compare_sequencer_shift = round_q[1:0];
      compare_sequencer_sr    = round_q[2];
      compare_sequencer_dir   = {round_q[1], ~round_q[1], round_q[0], ~round_q[0]};
    end
    compare_sequencer_tally = tally_q;
    compare_sequencer_round = round_q;
    compare_sequencer_err   = err_q;
  end

endmodule
